pio_gpio_irq: RTL and testbench
===============================

Name: pio_gpio_irq

Overview:
- Parametrised general-purpose PIO Avalon-MM slave. Successor to the fixed 3-bit input-only PIO used for the ADC channel-select readback.
- Adds configurable width, per-bit direction (bidirectional pins via out_port/oe), input synchronisation and edge capture.
- Adds a maskable level interrupt and atomic set/clear output registers.
- Sits between the NIOS II data master interconnect and board-level GPIO (ADC control lines, buttons, LEDs).

Parameters:
- WIDTH, 8, number of PIO bits (1..32)
- SYNC_STAGES, 2, synchroniser flops on in_port (2..4)
- EDGE_TYPE, 0, capture mode: 0 rising, 1 falling, 2 any edge
- RESET_OUT, 0, reset value of the output data register (WIDTH bits)
- RESET_DIR, 0, reset value of the direction register (1 = output)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- address  in  3  register word offset
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe, qualified by chipselect
- writedata  in  32  write data
- readdata  out  32  registered read data
- in_port  in  WIDTH  asynchronous pin inputs
- out_port  out  WIDTH  output data register
- oe  out  WIDTH  per-bit output enable (= direction register)
- irq  out  1  level interrupt to NIOS II

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset). Every flop clears or presets on reset assertion, independent of clk.
- Register map (word offsets):
  - 0 DATA: read returns sync_in; write loads out_reg.
  - 1 DIR: read/write.
  - 2 IRQMASK: read/write.
  - 3 EDGECAP: read; write 1 clears the bit.
  - 4 OUTSET: write-only, out_reg |= wd; reads 0.
  - 5 OUTCLR: write-only, out_reg &= ~wd; reads 0.
  - 6, 7: reserved; read 0; writes ignored.
- Write: takes effect on the clk edge where chipselect=1 and write_n=0. Only writedata[WIDTH-1:0] is used.
- Read: readdata is registered every cycle from address, giving fixed 1-cycle latency (valid the cycle after address is presented). Bits [31:WIDTH] are always 0. There is no read side-effect.
- Reset values: readdata=0, out_reg=RESET_OUT, dir=RESET_DIR, irqmask=0, edgecap=0, sync chain=0, prev=0, irq=0.
- Synchroniser: SYNC_STAGES flops per bit; sync_in is the last stage. in_port reaches DATA readback SYNC_STAGES+1 cycles after the pin changes (sync stages plus readdata register).
- Edge detect: prev <= sync_in each cycle.
  - rise = sync_in & ~prev; fall = ~sync_in & prev.
  - Mode select by EDGE_TYPE.
  - A bit is detected regardless of dir, so output bits looped back capture their own toggles.
- EDGECAP: sticky. Set at the edge where a bit's edge is detected.
  - Same-cycle edge and write-1-clear on the same bit: edge wins, bit stays 1.
  - Write 0: no effect.
- irq = |(edgecap & irqmask), registered (asserts 1 cycle after edgecap/irqmask update). Clearing the capture or mask deasserts it 1 cycle later.
- OUTSET/OUTCLR allow atomic bit updates without read-modify-write.
- out_port is driven from out_reg for all bits; the top level combines it with oe into tristates.
- Reset mid-transaction: the pending write is lost and the read returns 0. No bus stall; the slave has no waitrequest.
- After reset release, no edge is detected for the first SYNC_STAGES cycles when pins are low. A pin held high at reset produces one rising edge once it propagates; this is documented and software clears EDGECAP at init.

Decomposition:
- Package pio_gpio_pkg:
  - address constants ADDR_DATA..ADDR_OUTCLR.
  - EDGE_RISE/EDGE_FALL/EDGE_ANY localparams.
- Sub-module pio_sync_edge: WIDTH-wide synchroniser plus prev register plus edge-pulse output. Parameterised by WIDTH, SYNC_STAGES, EDGE_TYPE. Reused by future encoder/button blocks.
- Top level holds the register file, read mux and irq.

Test Plan:
- Reset: assert reset mid-cycle with out_reg=0xFF, then release → all outputs at reset values immediately (async); readdata=0; irq=0; out_port=RESET_OUT.
- Read latency (WIDTH=8): in_port=0xA5 held, read addr 0 → readdata=0x000000A5 exactly 1 cycle after the read; upper 24 bits 0. Read addr 6 → 0.
- Output atomics: write DATA=0x0F, OUTSET=0x30, OUTCLR=0x01 → out_port=0x3E; DIR=0xF0 → oe=0xF0.
- Edge capture (EDGE_TYPE=0): pulse in_port[3] 0→1→0 → EDGECAP=0x08; falling edge adds nothing. EDGE_TYPE=2 on the same stimulus → 0x08 set on both edges; clear with 0x08 → 0.
- IRQ: IRQMASK=0x08, edge on bit 3 → irq=1 one cycle after edgecap sets. Edge on bit 2 alone → irq stays 0. Write EDGECAP=0x08 → irq=0 after 1 cycle.
- Collision: a rising edge on bit 1 in the same cycle as write EDGECAP=0x02 → bit 1 remains 1 and irq remains asserted (if masked).

Source files
------------

// File: rtl/pio_gpio_pkg.sv
// Shared constants for the parametrised PIO: register word offsets and edge-capture modes.
package pio_gpio_pkg;

   localparam logic [2:0] ADDR_DATA    = 3'd0;
   localparam logic [2:0] ADDR_DIR     = 3'd1;
   localparam logic [2:0] ADDR_IRQMASK = 3'd2;
   localparam logic [2:0] ADDR_EDGECAP = 3'd3;
   localparam logic [2:0] ADDR_OUTSET  = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_sync_edge.sv
// Multi-bit pin synchroniser with a one-cycle history register and selectable edge pulses.
module pio_sync_edge
   import pio_gpio_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_TYPE   = EDGE_RISE
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] pin_i,
   output logic [WIDTH-1:0] sync_o,
   output logic [WIDTH-1:0] edge_o
);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0]                  prev_q;
   logic [WIDTH-1:0]                  rise;
   logic [WIDTH-1:0]                  fall;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign sync_o = sync_q[SYNC_STAGES-1];
   assign rise   = sync_o & ~prev_q;
   assign fall   = ~sync_o & prev_q;

   always_comb begin
      edge_o = rise;
      if (EDGE_TYPE == EDGE_FALL) begin
         edge_o = fall;
      end else if (EDGE_TYPE == EDGE_ANY) begin
         edge_o = rise | fall;
      end
   end

endmodule

// File: rtl/pio_gpio_irq.sv
// Avalon-MM GPIO slave: per-bit direction, sticky edge capture, maskable level irq,
// atomic set/clear of the output register and a fixed one-cycle registered read path.
module pio_gpio_irq
   import pio_gpio_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter int               SYNC_STAGES = 2,
   parameter int               EDGE_TYPE   = EDGE_RISE,
   parameter logic [WIDTH-1:0] RESET_OUT   = '0,
   parameter logic [WIDTH-1:0] RESET_DIR   = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] out_port,
   output logic [WIDTH-1:0] oe,
   output logic             irq
);

   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] dir_q, dir_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] cap_q, cap_d;
   logic             irq_q, irq_d;
   logic [31:0]      readdata_q, readdata_d;

   logic [WIDTH-1:0] sync_in;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] cap_clr;
   logic [WIDTH-1:0] rd_val;
   logic [WIDTH-1:0] wd;
   logic             wr_en;

   pio_sync_edge #(
      .WIDTH      (WIDTH),
      .SYNC_STAGES(SYNC_STAGES),
      .EDGE_TYPE  (EDGE_TYPE)
   ) u_sync_edge (
      .clk_i (clk),
      .rst_i (reset),
      .pin_i (in_port),
      .sync_o(sync_in),
      .edge_o(edge_det)
   );

   assign wr_en = chipselect & ~write_n;
   assign wd    = writedata[WIDTH-1:0];

   always_comb begin
      out_d   = out_q;
      dir_d   = dir_q;
      mask_d  = mask_q;
      cap_clr = '0;
      if (wr_en) begin
         case (address)
            ADDR_DATA:    out_d   = wd;
            ADDR_DIR:     dir_d   = wd;
            ADDR_IRQMASK: mask_d  = wd;
            ADDR_EDGECAP: cap_clr = wd;
            ADDR_OUTSET:  out_d   = out_q | wd;
            ADDR_OUTCLR:  out_d   = out_q & ~wd;
            default:      ;
         endcase
      end
      // A fresh edge overrides a same-cycle write-1-clear so no event is ever lost.
      cap_d = (cap_q & ~cap_clr) | edge_det;
      irq_d = |(cap_q & mask_q);
   end

   always_comb begin
      case (address)
         ADDR_DATA:    rd_val = sync_in;
         ADDR_DIR:     rd_val = dir_q;
         ADDR_IRQMASK: rd_val = mask_q;
         ADDR_EDGECAP: rd_val = cap_q;
         default:      rd_val = '0;
      endcase
      readdata_d             = '0;
      readdata_d[WIDTH-1:0]  = rd_val;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_q      <= RESET_OUT;
         dir_q      <= RESET_DIR;
         mask_q     <= '0;
         cap_q      <= '0;
         irq_q      <= 1'b0;
         readdata_q <= '0;
      end else begin
         out_q      <= out_d;
         dir_q      <= dir_d;
         mask_q     <= mask_d;
         cap_q      <= cap_d;
         irq_q      <= irq_d;
         readdata_q <= readdata_d;
      end
   end

   assign out_port = out_q;
   assign oe       = dir_q;
   assign irq      = irq_q;
   assign readdata = readdata_q;

endmodule

// File: tb/tb_pio_gpio_irq.sv
// Bench for pio_gpio_irq: a rising-edge instance and an any-edge instance share one bus;
// reads push expected words into a queue that a negedge monitor pops and compares.
module tb_pio_gpio_irq;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [7:0]  in_port = '0;
   logic [31:0] readdata0, readdata1;
   logic [7:0]  out_port0, out_port1, oe0, oe1;
   logic        irq0, irq1;

   int checks = 0;
   int errors = 0;
   logic rd_v = 1'b0;

   logic [31:0] exp_q[$];
   logic [31:0] exp2_q[$];
   string       name_q[$];

   always #5 clk = ~clk;

   pio_gpio_irq #(
      .WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .RESET_OUT(8'h00), .RESET_DIR(8'h00)
   ) u_dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata0),
      .in_port(in_port), .out_port(out_port0), .oe(oe0), .irq(irq0)
   );

   pio_gpio_irq #(
      .WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2), .RESET_OUT(8'h5A), .RESET_DIR(8'h0F)
   ) u_any (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata1),
      .in_port(in_port), .out_port(out_port1), .oe(oe1), .irq(irq1)
   );

   function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] e0, input logic [31:0] e1,
                     input string nm);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      exp_q.push_back(e0);
      exp2_q.push_back(e1);
      name_q.push_back(nm);
      @(posedge clk);
      #1;
      chipselect = 1'b0;
   endtask

   // A read presented on one edge is checked on the following negedge.
   always @(posedge clk) rd_v <= chipselect & write_n & ~reset;

   always @(negedge clk) begin : monitor
      logic [31:0] e0, e1;
      string nm;
      if (rd_v) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: unexpected read response %h", readdata0);
         end else begin
            e0 = exp_q.pop_front();
            e1 = exp2_q.pop_front();
            nm = name_q.pop_front();
            check({nm, " rise"}, readdata0, e0);
            check({nm, " any"}, readdata1, e1);
         end
      end
   end

   initial begin
      // Reset values while reset is held.
      idle(2);
      check("reset out_port rise", out_port0, 32'h00);
      check("reset out_port any", out_port1, 32'h5A);
      check("reset oe any", oe1, 32'h0F);
      check("reset irq", {irq1, irq0}, 32'h0);
      check("reset readdata", readdata0 | readdata1, 32'h0);
      reset = 1'b0;

      // Pin-to-readback latency is SYNC_STAGES+1 cycles.
      in_port = 8'hA5;
      rd(3'd0, 32'h0, 32'h0, "data lat1");
      rd(3'd0, 32'h0, 32'h0, "data lat2");
      rd(3'd0, 32'hA5, 32'hA5, "data lat3");
      rd(3'd6, 32'h0, 32'h0, "reserved 6");
      rd(3'd3, 32'hA5, 32'hA5, "edgecap A5");
      wr(3'd3, 32'hFF);
      rd(3'd3, 32'h0, 32'h0, "edgecap cleared");
      in_port = 8'h00;
      idle(4);
      rd(3'd3, 32'h0, 32'hA5, "edgecap fall");
      wr(3'd3, 32'hFF);
      rd(3'd3, 32'h0, 32'h0, "edgecap cleared 2");

      // Output atomics.
      wr(3'd0, 32'h0F);
      wr(3'd4, 32'h30);
      wr(3'd5, 32'h01);
      check("out_port atomics rise", out_port0, 32'h3E);
      check("out_port atomics any", out_port1, 32'h3E);
      wr(3'd4, 32'hFFFF_FF00);
      check("outset upper bits ignored", out_port0, 32'h3E);
      wr(3'd1, 32'hF0);
      check("oe rise", oe0, 32'hF0);
      check("oe any", oe1, 32'hF0);
      rd(3'd1, 32'hF0, 32'hF0, "dir read");
      rd(3'd4, 32'h0, 32'h0, "outset reads 0");
      rd(3'd5, 32'h0, 32'h0, "outclr reads 0");
      rd(3'd0, 32'h0, 32'h0, "data is pins");
      rd(3'd7, 32'h0, 32'h0, "reserved 7");

      // Edge capture on bit 3, rising then falling.
      in_port = 8'h08;
      idle(4);
      rd(3'd3, 32'h08, 32'h08, "cap rise b3");
      wr(3'd3, 32'h00);
      rd(3'd3, 32'h08, 32'h08, "write 0 no effect");
      wr(3'd3, 32'h08);
      rd(3'd3, 32'h0, 32'h0, "cap clr b3");
      in_port = 8'h00;
      idle(4);
      rd(3'd3, 32'h0, 32'h08, "cap fall b3");
      wr(3'd3, 32'h08);
      rd(3'd3, 32'h0, 32'h0, "cap clr b3 2");

      // irq latency: edgecap sets on edge 3 after the pin change, irq on edge 4.
      wr(3'd2, 32'h08);
      in_port = 8'h08;
      idle(3);
      check("irq not yet", {irq1, irq0}, 32'h0);
      idle(1);
      check("irq set rise", irq0, 32'h1);
      check("irq set any", irq1, 32'h1);
      rd(3'd2, 32'h08, 32'h08, "irqmask read");
      wr(3'd3, 32'h08);
      check("irq held 1 cycle after clear", irq0, 32'h1);
      idle(1);
      check("irq cleared", {irq1, irq0}, 32'h0);
      in_port = 8'h0C;
      idle(4);
      check("unmasked edge no irq", {irq1, irq0}, 32'h0);
      rd(3'd3, 32'h04, 32'h04, "cap b2");
      wr(3'd3, 32'h04);

      // Edge and write-1-clear colliding on bit 1.
      wr(3'd2, 32'h02);
      in_port = 8'h0E;
      idle(4);
      check("irq b1", {irq1, irq0}, 32'h3);
      in_port = 8'h0C;
      idle(4);
      in_port = 8'h0E;
      idle(2);
      wr(3'd3, 32'h02);
      check("collision irq", {irq1, irq0}, 32'h3);
      rd(3'd3, 32'h02, 32'h02, "collision edge wins");
      check("collision irq later", {irq1, irq0}, 32'h3);
      wr(3'd3, 32'h02);
      idle(1);
      check("irq after plain clear", {irq1, irq0}, 32'h0);

      // Asynchronous reset in the middle of a cycle.
      in_port = 8'h0C;
      idle(4);
      in_port = 8'h0E;
      idle(4);
      check("irq before reset", {irq1, irq0}, 32'h3);
      wr(3'd0, 32'hFF);
      check("out_port FF", out_port0, 32'hFF);
      address = 3'd1;
      idle(1);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("async out_port rise", out_port0, 32'h00);
      check("async out_port any", out_port1, 32'h5A);
      check("async oe", {oe1, oe0}, 32'h0F00);
      check("async irq", {irq1, irq0}, 32'h0);
      check("async readdata", readdata0 | readdata1, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // A pin held high through reset yields one rising edge after propagation.
      idle(4);
      rd(3'd3, 32'h0E, 32'h0E, "post-reset edge");
      rd(3'd1, 32'h00, 32'h0F, "post-reset dir");
      rd(3'd0, 32'h0E, 32'h0E, "post-reset data");
      check("post-reset irq", {irq1, irq0}, 32'h0);
      idle(2);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard drain: %0d left expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
